// File: rtl/iob_wb_pkg.sv
// Shared types and constants for the IOb-to-Wishbone bridge.
package iob_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_BUS  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_OVL  = 2'b11;

    // Byte-address bits dropped to form the Wishbone word address.
    function automatic int adr_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/iob_wb_bridge_if.sv
// IOb request/response and Wishbone bus signals; the bridge sees the IOb side
// through the slave modport and the Wishbone side through the master modport.
interface iob_wb_bridge_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    localparam int AW = ADDR_W - iob_wb_pkg::adr_shift(DATA_W);

    logic              iob_valid;
    logic [ADDR_W-1:0] iob_addr;
    logic [DATA_W-1:0] iob_wdata;
    logic [DATA_W/8-1:0] iob_wstrb;
    logic [DATA_W-1:0] iob_rdata;
    logic              iob_ready;

    logic [AW-1:0]     wb_adr_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W/8-1:0] wb_sel_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_ack_i;
    logic              wb_err_i;
    logic              wb_stall_i;

    modport slave (
        input  iob_valid, iob_addr, iob_wdata, iob_wstrb,
        output iob_rdata, iob_ready
    );

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
    );
endinterface

// File: rtl/iob_wb_err_log.sv
// Sticky first-error register; a new error arriving with a clear is kept.
module iob_wb_err_log
    import iob_wb_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_i,
    input  logic [1:0]        code_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              clr_i,
    output logic              err_o,
    output logic [1:0]        code_o,
    output logic [ADDR_W-1:0] addr_o
);
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        err_d  = err_q;
        code_d = code_q;
        addr_d = addr_q;
        if (clr_i) begin
            err_d  = 1'b0;
            code_d = ERR_NONE;
            addr_d = '0;
        end
        if (set_i && (!err_q || clr_i)) begin
            err_d  = 1'b1;
            code_d = code_i;
            addr_d = addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
            addr_q <= '0;
        end else begin
            err_q  <= err_d;
            code_q <= code_d;
            addr_q <= addr_d;
        end
    end

    assign err_o  = err_q;
    assign code_o = code_q;
    assign addr_o = addr_q;
endmodule

// File: rtl/iob_wb_bridge.sv
// IOb slave to Wishbone B4 master: one registered request, one Wishbone cycle,
// with bounded retry on bus error, a cycle timeout and a sticky error log.
module iob_wb_bridge
    import iob_wb_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter int          DATA_W    = 32,
    parameter bit          PIPELINED = 1'b0,
    parameter int          TIMEOUT   = 256,
    parameter int          TIMEOUT_W = 9,
    parameter int          RETRIES   = 1,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    iob_wb_bridge_if.slave    iob,
    iob_wb_bridge_if.master   wb,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [ADDR_W-1:0] err_addr_o,
    input  logic              err_clr_i
);
    localparam int SHIFT = adr_shift(DATA_W);
    localparam int AW    = ADDR_W - SHIFT;
    localparam int SEL_W = DATA_W / 8;
    localparam int RTY_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
    localparam logic [DATA_W-1:0] ERR_RD = DATA_W'(ERR_RDATA);

    state_e              state_q, state_d;
    logic [AW-1:0]       adr_q, adr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic                gap_q, gap_d;
    logic [RTY_W-1:0]    rty_q, rty_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

    logic              busy, accept, tmo_hit, in_flight;
    logic              log_set;
    logic [1:0]        log_code;
    logic [ADDR_W-1:0] log_addr;

    // gap_q marks the one idle cycle between an errored attempt and its re-issue.
    assign busy      = (state_q == REQ && !gap_q) || state_q == WAIT;
    assign in_flight = state_q == REQ || state_q == WAIT;
    assign accept    = iob.iob_valid && (state_q == IDLE || state_q == RESP);
    assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TIMEOUT_W'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        addr_d   = addr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        gap_d    = 1'b0;
        rty_d    = rty_q;
        tmo_d    = tmo_q;
        rdata_d  = rdata_q;
        log_set  = 1'b0;
        log_code = ERR_NONE;
        log_addr = addr_q;

        if (state_q == RESP) state_d = IDLE;

        if (accept) begin
            adr_d   = iob.iob_addr[ADDR_W-1:SHIFT];
            addr_d  = iob.iob_addr;
            dat_d   = iob.iob_wdata;
            we_d    = |iob.iob_wstrb;
            sel_d   = (|iob.iob_wstrb) ? iob.iob_wstrb : '1;
            rty_d   = '0;
            tmo_d   = '0;
            state_d = REQ;
        end else if (state_q == REQ && gap_q) begin
            tmo_d = '0;
        end else if (busy) begin
            if (wb.wb_err_i) begin
                if (rty_q < RTY_W'(RETRIES)) begin
                    rty_d   = rty_q + 1'b1;
                    gap_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = REQ;
                end else begin
                    rdata_d  = ERR_RD;
                    log_set  = 1'b1;
                    log_code = ERR_BUS;
                    state_d  = RESP;
                end
            end else if (wb.wb_ack_i) begin
                rdata_d = we_q ? '0 : wb.wb_dat_i;
                state_d = RESP;
            end else if (tmo_hit) begin
                rdata_d  = ERR_RD;
                log_set  = 1'b1;
                log_code = ERR_TMO;
                state_d  = RESP;
            end else begin
                tmo_d = tmo_q + 1'b1;
                if (PIPELINED && state_q == REQ && !wb.wb_stall_i) state_d = WAIT;
            end
        end

        // A request arriving mid-cycle is dropped; bus/timeout errors take the log slot first.
        if (in_flight && iob.iob_valid && !log_set) begin
            log_set  = 1'b1;
            log_code = ERR_OVL;
            log_addr = iob.iob_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            adr_q   <= '0;
            addr_q  <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            gap_q   <= 1'b0;
            rty_q   <= '0;
            tmo_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            gap_q   <= gap_d;
            rty_q   <= rty_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
        end
    end

    assign wb.wb_cyc_o  = busy;
    assign wb.wb_stb_o  = state_q == REQ && !gap_q;
    assign wb.wb_adr_o  = adr_q;
    assign wb.wb_dat_o  = dat_q;
    assign wb.wb_sel_o  = sel_q;
    assign wb.wb_we_o   = we_q;
    assign iob.iob_ready = state_q == RESP;
    assign iob.iob_rdata = rdata_q;

    iob_wb_err_log #(.ADDR_W(ADDR_W)) u_err_log (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_i  (log_set),
        .code_i (log_code),
        .addr_i (log_addr),
        .clr_i  (err_clr_i),
        .err_o  (err_o),
        .code_o (err_code_o),
        .addr_o (err_addr_o)
    );
endmodule

// File: tb/tb_iob_wb_bridge.sv
// Directed bench for iob_wb_bridge: a classic and a pipelined instance, with
// expected responses queued at issue time and popped by per-instance monitors.
module tb_iob_wb_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] q_c[$];
    logic [31:0] q_p[$];

    iob_wb_bridge_if #(.ADDR_W(12), .DATA_W(32)) c_if ();
    iob_wb_bridge_if #(.ADDR_W(12), .DATA_W(32)) p_if ();

    logic        c_err, p_err, c_clr, p_clr;
    logic [1:0]  c_code, p_code;
    logic [11:0] c_eaddr, p_eaddr;

    iob_wb_bridge #(.PIPELINED(1'b0), .TIMEOUT(8), .TIMEOUT_W(4), .RETRIES(1)) u_cls (
        .clk(clk), .rst_n(rst_n), .iob(c_if), .wb(c_if),
        .err_o(c_err), .err_code_o(c_code), .err_addr_o(c_eaddr), .err_clr_i(c_clr)
    );

    iob_wb_bridge #(.PIPELINED(1'b1), .TIMEOUT(8), .TIMEOUT_W(4), .RETRIES(1)) u_pip (
        .clk(clk), .rst_n(rst_n), .iob(p_if), .wb(p_if),
        .err_o(p_err), .err_code_o(p_code), .err_addr_o(p_eaddr), .err_clr_i(p_clr)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && c_if.iob_ready) begin
            if (q_c.size() == 0) check("c_unexpected_ready", 64'd1, 64'd0);
            else check("c_rdata", 64'(c_if.iob_rdata), 64'(q_c.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst_n && p_if.iob_ready) begin
            if (q_p.size() == 0) check("p_unexpected_ready", 64'd1, 64'd0);
            else check("p_rdata", 64'(p_if.iob_rdata), 64'(q_p.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit pip, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        if (pip) begin
            p_if.iob_valid = 1'b1; p_if.iob_addr = a; p_if.iob_wdata = d; p_if.iob_wstrb = s;
        end else begin
            c_if.iob_valid = 1'b1; c_if.iob_addr = a; c_if.iob_wdata = d; c_if.iob_wstrb = s;
        end
        tick();
        c_if.iob_valid = 1'b0;
        p_if.iob_valid = 1'b0;
    endtask

    initial begin
        c_if.iob_valid = 0; c_if.iob_addr = 0; c_if.iob_wdata = 0; c_if.iob_wstrb = 0;
        c_if.wb_dat_i = 0; c_if.wb_ack_i = 0; c_if.wb_err_i = 0; c_if.wb_stall_i = 0;
        p_if.iob_valid = 0; p_if.iob_addr = 0; p_if.iob_wdata = 0; p_if.iob_wstrb = 0;
        p_if.wb_dat_i = 0; p_if.wb_ack_i = 0; p_if.wb_err_i = 0; p_if.wb_stall_i = 0;
        c_clr = 0; p_clr = 0;

        #3;
        check("rst_cyc", 64'(c_if.wb_cyc_o), 0);
        check("rst_stb", 64'(p_if.wb_stb_o), 0);
        check("rst_ready", 64'(c_if.iob_ready), 0);
        check("rst_err", 64'(c_err), 0);
        #9 rst_n = 1'b1;
        tick();

        // classic read, ack on the 3rd cycle of cyc
        q_c.push_back(32'h12345678);
        issue(0, 12'h010, 32'h0, 4'h0);
        check("t1_cyc", 64'(c_if.wb_cyc_o), 1);
        check("t1_stb", 64'(c_if.wb_stb_o), 1);
        check("t1_sel", 64'(c_if.wb_sel_o), 64'hF);
        check("t1_we", 64'(c_if.wb_we_o), 0);
        check("t1_adr", 64'(c_if.wb_adr_o), 64'h004);
        tick();
        tick();
        c_if.wb_ack_i = 1; c_if.wb_dat_i = 32'h12345678;
        tick();
        c_if.wb_ack_i = 0;
        check("t1_ready", 64'(c_if.iob_ready), 1);
        tick();
        check("t1_idle", 64'(c_if.wb_cyc_o), 0);

        // retry: err, idle cycle, then ack on re-issue
        q_c.push_back(32'hA5A50001);
        issue(0, 12'h020, 32'h0, 4'h0);
        check("t3_stb1", 64'(c_if.wb_stb_o), 1);
        c_if.wb_err_i = 1;
        tick();
        c_if.wb_err_i = 0;
        check("t3_gap_cyc", 64'(c_if.wb_cyc_o), 0);
        check("t3_gap_stb", 64'(c_if.wb_stb_o), 0);
        tick();
        check("t3_stb2", 64'(c_if.wb_stb_o), 1);
        c_if.wb_ack_i = 1; c_if.wb_dat_i = 32'hA5A50001;
        tick();
        c_if.wb_ack_i = 0;
        check("t3_err_o", 64'(c_err), 0);
        tick();

        // timeout: slave never answers
        q_c.push_back(32'hDEADBEEF);
        issue(0, 12'h0C4, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            check("t4_cyc_held", 64'(c_if.wb_cyc_o), 1);
            tick();
        end
        check("t4_cyc_drop", 64'(c_if.wb_cyc_o), 0);
        check("t4_err_o", 64'(c_err), 1);
        check("t4_code", 64'(c_code), 64'h2);
        check("t4_addr", 64'(c_eaddr), 64'h0C4);
        c_clr = 1;
        tick();
        c_clr = 0;
        check("t4_clr_err", 64'(c_err), 0);
        check("t4_clr_code", 64'(c_code), 0);

        // minimum latency and back-to-back request in the RESP cycle
        q_c.push_back(32'h11110000);
        q_c.push_back(32'h0);
        issue(0, 12'h100, 32'h0, 4'h0);
        c_if.wb_ack_i = 1; c_if.wb_dat_i = 32'h11110000;
        tick();
        c_if.wb_ack_i = 0;
        check("t6_ready", 64'(c_if.iob_ready), 1);
        c_if.iob_valid = 1; c_if.iob_addr = 12'h104; c_if.iob_wdata = 32'h55AA55AA; c_if.iob_wstrb = 4'hF;
        tick();
        c_if.iob_valid = 0;
        check("t6_cyc", 64'(c_if.wb_cyc_o), 1);
        check("t6_we", 64'(c_if.wb_we_o), 1);
        check("t6_adr", 64'(c_if.wb_adr_o), 64'h041);
        check("t6_dat", 64'(c_if.wb_dat_o), 64'h55AA55AA);
        c_if.wb_ack_i = 1;
        tick();
        c_if.wb_ack_i = 0;
        tick();

        // pipelined write with two stall cycles
        q_p.push_back(32'h0);
        p_if.wb_stall_i = 1;
        issue(1, 12'h014, 32'hCAFEBEEF, 4'h3);
        check("t2_adr", 64'(p_if.wb_adr_o), 64'h005);
        check("t2_sel", 64'(p_if.wb_sel_o), 64'h3);
        check("t2_we", 64'(p_if.wb_we_o), 1);
        check("t2_dat", 64'(p_if.wb_dat_o), 64'hCAFEBEEF);
        tick();
        check("t2_stb_stall1", 64'(p_if.wb_stb_o), 1);
        tick();
        check("t2_stb_stall2", 64'(p_if.wb_stb_o), 1);
        p_if.wb_stall_i = 0;
        tick();
        check("t2_stb_drop", 64'(p_if.wb_stb_o), 0);
        check("t2_cyc_wait", 64'(p_if.wb_cyc_o), 1);
        p_if.wb_ack_i = 1;
        tick();
        p_if.wb_ack_i = 0;
        check("t2_ready", 64'(p_if.iob_ready), 1);
        tick();

        // overlap in WAIT, then a bus error arriving with err_clr
        q_p.push_back(32'hDEADBEEF);
        issue(1, 12'h040, 32'h0, 4'h0);
        tick();
        check("t5_wait_stb", 64'(p_if.wb_stb_o), 0);
        p_if.iob_valid = 1; p_if.iob_addr = 12'h088;
        tick();
        p_if.iob_valid = 0;
        check("t5_ovl_err", 64'(p_err), 1);
        check("t5_ovl_code", 64'(p_code), 64'h3);
        check("t5_ovl_addr", 64'(p_eaddr), 64'h088);
        p_if.wb_err_i = 1;
        tick();
        p_if.wb_err_i = 0;
        check("t5_gap_cyc", 64'(p_if.wb_cyc_o), 0);
        tick();
        check("t5_reissue_stb", 64'(p_if.wb_stb_o), 1);
        p_if.wb_err_i = 1; p_clr = 1;
        tick();
        p_if.wb_err_i = 0; p_clr = 0;
        check("t5_new_err", 64'(p_err), 1);
        check("t5_new_code", 64'(p_code), 64'h1);
        check("t5_new_addr", 64'(p_eaddr), 64'h040);
        tick();

        // reset in the middle of a cycle
        issue(0, 12'h200, 32'h0, 4'h0);
        check("t7_cyc_pre", 64'(c_if.wb_cyc_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_cyc", 64'(c_if.wb_cyc_o), 0);
        check("t7_stb", 64'(c_if.wb_stb_o), 0);
        check("t7_adr", 64'(c_if.wb_adr_o), 0);
        check("t7_ready", 64'(c_if.iob_ready), 0);
        check("t7_p_err", 64'(p_err), 0);
        #2 rst_n = 1'b1;
        tick();
        tick();
        check("t7_idle", 64'(c_if.wb_cyc_o), 0);
        tick();

        check("c_queue_empty", 64'(q_c.size()), 0);
        check("p_queue_empty", 64'(q_p.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
